sy_fifo: RTL and testbench
==========================

Name: sy_fifo

Overview:
Parametrised synchronous FIFO built on the team's single-clock dual-port RAM. It adds pointer management, occupancy count, full/empty and almost-full/almost-empty flags, and sticky overflow/underflow error flags. It keeps the codebase's active-low cs_n/wr_n/rd_n strobe interface. It is the buffering stage between byte-stream producers and consumers that share one clock.

Parameters:
WD, 8, data width in bits (1..64)
DP, 16, depth in words; power of 2, minimum 4
AF_TH, DP-2, afull asserts when occupancy >= AF_TH (1..DP)
AE_TH, 2, aempty asserts when occupancy <= AE_TH (0..DP-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
clr  in  1  synchronous flush, active-high
cs_n  in  1  chip select, active-low; when 1 no read/write accepted
wr_n  in  1  write strobe, active-low
rd_n  in  1  read strobe, active-low
din  in  WD  write data
dout  out  WD  read data, registered
dout_vld  out  1  one-cycle pulse, dout updated this cycle
full  out  1  occupancy == DP
empty  out  1  occupancy == 0
afull  out  1  occupancy >= AF_TH
aempty  out  1  occupancy <= AE_TH
cnt  out  AW+1  occupancy 0..DP, where AW = clog2(DP)
ovf  out  1  sticky: write attempted while full with no read
udf  out  1  sticky: read attempted while empty

Behaviour:
- Reset: rst_n=0 at a clock edge sets wptr=rptr=0, cnt=0, empty=1, full=0, aempty=1, afull=0, dout=0, dout_vld=0, ovf=0, udf=0. RAM contents are not cleared. Reset has priority over everything.
- clr=1 (with rst_n=1): same effect as reset, except ovf and udf hold. clr takes priority over a read or write in the same cycle.
- wr_acc = !cs_n & !wr_n & (!full | rd_acc). Data is written at wptr, and wptr increments modulo DP.
- rd_acc = !cs_n & !rd_n & !empty. The RAM word at rptr appears on dout at the next edge (latency 1), and dout_vld=1 for that one cycle. rptr increments modulo DP.
- No accepted read: dout holds its last value and dout_vld=0.
- Rejected write (full, no read accepted): data dropped, ovf<=1. Rejected read (empty): udf<=1, dout held. Both flags clear only on reset.
- Simultaneous read and write:
  - Not empty: both accepted, cnt unchanged.
  - Full: both accepted, no ovf.
  - Empty: write accepted, read rejected (no fall-through), udf<=1, cnt becomes 1.
- cnt_next = cnt + wr_acc - rd_acc. All flags are registered and computed from cnt_next, so they are valid in the same cycle as cnt.
- Pointers are AW bits and wrap naturally. full is distinguished from empty by cnt, not by pointer equality.
- cs_n=1: strobes ignored, state holds, no error flags set.
- Reset mid-burst: the pending dout_vld is cancelled. The first read after reset returns data written after reset.

Decomposition:
- No package required. AW = clog2(DP) is a localparam.
- Add a shared header constant for the default thresholds if other FIFOs adopt the same defaults.
- One sub-module: sy_dpram (WD, DP) as storage.
  - B port: internal write enable, addr = wptr, din.
  - A port: addr = rptr, registered dout_a.
  - Tie its cs_n low. Drive its wr_n = ~wr_acc and rd_n = ~rd_acc.
- Control logic (pointers, counter, flags, errors) lives in sy_fifo.

Test Plan:
1. Hold rst_n=0 for 2 cycles -> cnt=0, empty=1, aempty=1, full=0, afull=0, dout=8'h00, dout_vld=0, ovf=0, udf=0.
2. Write 0xA0..0xAF on 16 consecutive cycles -> afull=1 after the 14th write, full=1 and cnt=16 after the 16th. A 17th write of 0xFF -> dropped, ovf=1, cnt=16.
3. Read 16 consecutive cycles -> dout=0xA0..0xAF, each one cycle after its read with dout_vld=1. empty=1 after the last read. A 17th read -> udf=1, dout stays 0xAF, dout_vld=0.
4. Fill to cnt=8, then read and write simultaneously for 20 cycles with din=0xB0+i -> cnt stays 8, pointers wrap past 15. Output order is the 8 prefilled words, then 0xB0, 0xB1, and so on.
5. Edge simultaneity:
   - Read and write together at full -> full stays 1, ovf stays 0.
   - Read and write together at empty with din=0x55 -> cnt=1, udf=1, no dout_vld. A subsequent read returns 0x55.
6. Mid-operation reset and flush:
   - At cnt=5, pulse clr with a write pending -> next cycle cnt=0, empty=1, ovf/udf unchanged. Write 0x3C then read -> dout=0x3C.
   - Repeat with rst_n=0 -> ovf/udf also cleared.

Source files
------------

// File: rtl/sy_dpram.sv
`default_nettype none
// ============================================================================
// Module      : sy_dpram
// Description : Single-clock dual-port RAM, port B write, port A registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module sy_dpram #(
    parameter int WD = 8,
    parameter int DP = 16,
    parameter int AW = $clog2(DP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          cs_n,
    input  logic          wr_n,
    input  logic          rd_n,
    input  logic [AW-1:0] addr_a,
    output logic [WD-1:0] dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic [WD-1:0] din_b
);

    logic [WD-1:0] r_mem [DP];
    logic [WD-1:0] r_dout_a;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!cs_n && !wr_n) begin
            r_mem[addr_b] <= din_b;
        end
    end

    // Only the output register is cleared; a same-address write returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_dout_a <= '0;
        end else if (!cs_n && !rd_n) begin
            r_dout_a <= r_mem[addr_a];
        end
    end

    assign dout_a = r_dout_a;

endmodule
`default_nettype wire

// File: rtl/sy_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sy_fifo
// Description : Synchronous FIFO with occupancy count, threshold and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sy_fifo #(
    parameter int WD    = 8,
    parameter int DP    = 16,
    parameter int AF_TH = DP - 2,
    parameter int AE_TH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    cs_n,
    input  logic                    wr_n,
    input  logic                    rd_n,
    input  logic [WD-1:0]           din,
    output logic [WD-1:0]           dout,
    output logic                    dout_vld,
    output logic                    full,
    output logic                    empty,
    output logic                    afull,
    output logic                    aempty,
    output logic [$clog2(DP):0]     cnt,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = $clog2(DP);
    localparam logic [AW:0] c_dp    = (AW+1)'(DP);
    localparam logic [AW:0] c_af_th = (AW+1)'(AF_TH);
    localparam logic [AW:0] c_ae_th = (AW+1)'(AE_TH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_dout_vld;
    logic          r_ovf;
    logic          r_udf;

    logic          w_active;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [AW:0]   w_cnt_next;

    // Reset and flush both suppress acceptance so the RAM sees no strobe.
    assign w_active   = rst_n & ~clr;
    assign w_rd_acc   = w_active & ~cs_n & ~rd_n & ~r_empty;
    assign w_wr_acc   = w_active & ~cs_n & ~wr_n & (~r_full | w_rd_acc);
    assign w_cnt_next = r_cnt + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_dout_vld <= 1'b0;
            if (!rst_n) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
            r_cnt      <= w_cnt_next;
            r_full     <= (w_cnt_next == c_dp);
            r_empty    <= (w_cnt_next == '0);
            r_afull    <= (w_cnt_next >= c_af_th);
            r_aempty   <= (w_cnt_next <= c_ae_th);
            r_dout_vld <= w_rd_acc;
            if (!cs_n && !wr_n && r_full && !w_rd_acc) r_ovf <= 1'b1;
            if (!cs_n && !rd_n && r_empty)             r_udf <= 1'b1;
        end
    end

    sy_dpram #(
        .WD (WD),
        .DP (DP),
        .AW (AW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .cs_n   (1'b0),
        .wr_n   (~w_wr_acc),
        .rd_n   (~w_rd_acc),
        .addr_a (r_rptr),
        .dout_a (dout),
        .addr_b (r_wptr),
        .din_b  (din)
    );

    assign dout_vld = r_dout_vld;
    assign full     = r_full;
    assign empty    = r_empty;
    assign afull    = r_afull;
    assign aempty   = r_aempty;
    assign cnt      = r_cnt;
    assign ovf      = r_ovf;
    assign udf      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sy_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sy_fifo
// Description : Randomised and directed bench for sy_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sy_fifo;

    localparam int WD    = 8;
    localparam int DP    = 16;
    localparam int AF_TH = DP - 2;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          rst_n, clr, cs_n, wr_n, rd_n;
    logic [WD-1:0] din;
    logic [WD-1:0] dout;
    logic          dout_vld, full, empty, afull, aempty, ovf, udf;
    logic [4:0]    cnt;

    always #5 clk = ~clk;

    sy_fifo #(
        .WD    (WD),
        .DP    (DP),
        .AF_TH (AF_TH),
        .AE_TH (AE_TH)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cs_n     (cs_n),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .full     (full),
        .empty    (empty),
        .afull    (afull),
        .aempty   (aempty),
        .cnt      (cnt),
        .ovf      (ovf),
        .udf      (udf)
    );

    logic [WD-1:0] m_q [$];
    logic [WD-1:0] m_dout;
    logic          m_vld, m_ovf, m_udf;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference behaviour: a bounded queue with the accept/reject rules.
    task automatic model_update();
        bit rd_ok, wr_ok;
        if (!rst_n) begin
            m_q.delete();
            m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0;
        end else if (clr) begin
            m_q.delete();
            m_dout = '0; m_vld = 0;
        end else if (!cs_n) begin
            rd_ok = !rd_n && (m_q.size() > 0);
            wr_ok = !wr_n && ((m_q.size() < DP) || rd_ok);
            if (!rd_n && m_q.size() == 0) m_udf = 1;
            if (!wr_n && !wr_ok)          m_ovf = 1;
            m_vld = rd_ok;
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(din);
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        check("cnt",      64'(cnt),      64'(sz));
        check("full",     64'(full),     64'(sz == DP));
        check("empty",    64'(empty),    64'(sz == 0));
        check("afull",    64'(afull),    64'(sz >= AF_TH));
        check("aempty",   64'(aempty),   64'(sz <= AE_TH));
        check("dout",     64'(dout),     64'(m_dout));
        check("dout_vld", 64'(dout_vld), 64'(m_vld));
        check("ovf",      64'(ovf),      64'(m_ovf));
        check("udf",      64'(udf),      64'(m_udf));
    endtask

    task automatic step(input logic r, input logic c, input logic cs,
                        input logic w, input logic rd, input logic [WD-1:0] d);
        rst_n = r; clr = c; cs_n = cs; wr_n = w; rd_n = rd; din = d;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [WD-1:0] d); step(1, 0, 0, 0, 1, d); endtask
    task automatic rd();                       step(1, 0, 0, 1, 0, '0); endtask
    task automatic rw(input logic [WD-1:0] d); step(1, 0, 0, 0, 0, d); endtask
    task automatic rst();                      step(0, 0, 1, 1, 1, '0); endtask

    initial begin
        int wp, rp;
        rst_n = 0; clr = 0; cs_n = 1; wr_n = 1; rd_n = 1; din = '0;

        rst(); rst();

        for (int i = 0; i < 16; i++) wr(WD'(8'hA0 + i));
        wr(8'hFF);
        for (int i = 0; i < 17; i++) rd();

        for (int i = 0; i < 8; i++)  wr(WD'(i));
        for (int i = 0; i < 20; i++) rw(WD'(8'hB0 + i));
        for (int i = 0; i < 8; i++)  rd();

        rst();
        for (int i = 0; i < 16; i++) wr(WD'(8'hC0 + i));
        rw(8'h99);
        for (int i = 0; i < 16; i++) rd();
        rw(8'h55);
        rd();

        for (int i = 0; i < 5; i++) wr(WD'(8'h10 + i));
        step(1, 1, 0, 0, 1, 8'h77);
        wr(8'h3C); rd();
        for (int i = 0; i < 5; i++) wr(WD'(8'h20 + i));
        step(0, 0, 0, 0, 1, 8'h77);
        wr(8'h3C); rd();

        // Random phases bias fill/drain so full and empty are both reached.
        wp = 50; rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0),
                 !($urandom_range(0, 99) < wp),
                 !($urandom_range(0, 99) < rp),
                 WD'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
